// File: rtl/regwb_arbiter.sv
// regwb_arbiter: shares the register-file write port between the pipeline writeback
// and a 2-entry buffer of long-latency results, with starvation hold and WAW squash.
module regwb_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  input  logic        mu_valid_i,
  input  logic [4:0]  mu_addr_i,
  input  logic [31:0] mu_data_i,
  output logic        mu_ready_o,
  input  logic [4:0]  RSaddr_i,
  input  logic [4:0]  RTaddr_i,
  input  logic [4:0]  RDaddr_i,
  output logic        hazard_o,
  output logic        wb_stall_o,
  output logic        RegWrite_o,
  output logic [4:0]  RDaddr_o,
  output logic [31:0] RDdata_o
);
  localparam int CW = $clog2(STARVE_MAX) + 1;
  typedef enum logic {NORMAL, HOLD} state_t;
  state_t state_q, state_d;
  logic [1:0] count_q, count_d, valid_q, valid_d, sq, cnt_mid;
  logic head_q, head_d, tail_q, tail_d, head_mid, wr_slot;
  logic live0, live1, pipe_gnt, fifo_gnt, push, last;
  logic [CW-1:0] starve_q, starve_d;
  logic [4:0] addr_q [2];
  logic [31:0] data_q [2];
  function automatic logic hit(input logic [4:0] a);
    return a != 5'd0 && (a == RSaddr_i || a == RTaddr_i || a == RDaddr_i);
  endfunction
  always_comb begin
    mu_ready_o = count_q < 2'd2;
    wb_stall_o = state_q == HOLD;
    pipe_gnt = rst_i && wb_valid_i && !wb_stall_o;
    fifo_gnt = rst_i && !pipe_gnt && count_q != 2'd0;
    push = mu_valid_i && mu_ready_o && mu_addr_i != 5'd0;
    RegWrite_o = pipe_gnt ? wb_addr_i != 5'd0 : fifo_gnt;
    RDaddr_o = pipe_gnt ? wb_addr_i : fifo_gnt ? addr_q[head_q] : 5'd0;
    RDdata_o = pipe_gnt ? wb_data_i : fifo_gnt ? data_q[head_q] : 32'd0;
    hazard_o = rst_i && mu_valid_i && hit(mu_addr_i);
    for (int i = 0; i < 2; i++) begin
      hazard_o = hazard_o | (rst_i && valid_q[i] && hit(addr_q[i]));
      sq[i] = pipe_gnt && wb_addr_i != 5'd0 && valid_q[i] && addr_q[i] == wb_addr_i;
    end
    // Squash may remove either slot; the survivor becomes the head so it is never skipped.
    live0 = valid_q[head_q] && !sq[head_q];
    live1 = valid_q[!head_q] && !sq[!head_q];
    head_mid = fifo_gnt ? !head_q : (!live0 && live1) ? !head_q : head_q;
    cnt_mid = fifo_gnt ? count_q - 2'd1 : {live0 && live1, live0 ^ live1};
    wr_slot = |sq ? head_mid ^ cnt_mid[0] : tail_q;
    count_d = cnt_mid + {1'b0, push};
    head_d = head_mid;
    tail_d = head_d ^ count_d[0];
    valid_d = count_d == 2'd2 ? 2'b11 : count_d == 2'd0 ? 2'b00 : head_d ? 2'b10 : 2'b01;
    last = starve_q == CW'(STARVE_MAX - 1);
    state_d = wb_stall_o ? (fifo_gnt ? NORMAL : HOLD)
            : (count_q == 2'd2 && pipe_gnt && last) ? HOLD : NORMAL;
    starve_d = (!wb_stall_o && count_q == 2'd2 && pipe_gnt && !last) ? starve_q + 1'b1 : '0;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= NORMAL;
      count_q  <= '0;
      valid_q  <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      starve_q <= starve_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[wr_slot] <= mu_addr_i;
      data_q[wr_slot] <= mu_data_i;
    end
  end
endmodule

// File: tb/tb_regwb_arbiter.sv
// tb_regwb_arbiter: directed scenarios plus random traffic checked against a queue model.
module tb_regwb_arbiter;
  localparam int STARVE_MAX = 4;
  logic clk = 1'b0, rst_i = 1'b0;
  logic wb_valid_i = 0, mu_valid_i = 0;
  logic [4:0] wb_addr_i = 0, mu_addr_i = 0, RSaddr_i = 0, RTaddr_i = 0, RDaddr_i = 0;
  logic [31:0] wb_data_i = 0, mu_data_i = 0;
  logic mu_ready_o, hazard_o, wb_stall_o, RegWrite_o;
  logic [4:0] RDaddr_o;
  logic [31:0] RDdata_o;
  typedef struct {logic [4:0] a; logic [31:0] d;} ent_t;
  ent_t q[$];
  int scnt = 0;
  bit hold = 0;
  int ncmp = 0, nmis = 0;
  regwb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .rst_i(rst_i), .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i),
    .wb_data_i(wb_data_i), .mu_valid_i(mu_valid_i), .mu_addr_i(mu_addr_i),
    .mu_data_i(mu_data_i), .mu_ready_o(mu_ready_o), .RSaddr_i(RSaddr_i),
    .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i), .hazard_o(hazard_o),
    .wb_stall_o(wb_stall_o), .RegWrite_o(RegWrite_o), .RDaddr_o(RDaddr_o),
    .RDdata_o(RDdata_o));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit hit(input logic [4:0] a);
    return a != 0 && (a == RSaddr_i || a == RTaddr_i || a == RDaddr_i);
  endfunction
  task automatic idle();
    wb_valid_i = 0; wb_addr_i = 0; wb_data_i = 0;
    mu_valid_i = 0; mu_addr_i = 0; mu_data_i = 0;
    RSaddr_i = 0; RTaddr_i = 0; RDaddr_i = 0;
  endtask
  task automatic set_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb_valid_i = v; wb_addr_i = a; wb_data_i = d;
  endtask
  task automatic set_mu(input logic v, input logic [4:0] a, input logic [31:0] d);
    mu_valid_i = v; mu_addr_i = a; mu_data_i = d;
  endtask
  task automatic tick();
    bit pg, fg, push, eh;
    logic [4:0] ea;
    logic [31:0] ed;
    @(negedge clk);
    pg = wb_valid_i && !hold;
    fg = !pg && q.size() > 0;
    ea = pg ? wb_addr_i : fg ? q[0].a : 5'd0;
    ed = pg ? wb_data_i : fg ? q[0].d : 32'd0;
    eh = mu_valid_i && hit(mu_addr_i);
    foreach (q[i]) if (hit(q[i].a)) eh = 1;
    chk("mu_ready", mu_ready_o, q.size() < 2);
    chk("wb_stall", wb_stall_o, hold);
    chk("hazard", hazard_o, eh);
    chk("RegWrite", RegWrite_o, pg ? wb_addr_i != 0 : fg);
    chk("RDaddr", RDaddr_o, ea);
    chk("RDdata", RDdata_o, ed);
    push = mu_valid_i && q.size() < 2 && mu_addr_i != 0;
    if (hold) begin
      if (fg) begin hold = 0; scnt = 0; end
    end else if (q.size() == 2 && pg) begin
      if (scnt == STARVE_MAX - 1) begin hold = 1; scnt = 0; end
      else scnt++;
    end else scnt = 0;
    if (pg && wb_addr_i != 0)
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].a == wb_addr_i) q.delete(i);
    if (fg) void'(q.pop_front());
    if (push) q.push_back('{mu_addr_i, mu_data_i});
    @(posedge clk); #1;
  endtask
  initial begin
    #2;
    chk("rst_mu_ready", mu_ready_o, 1);
    chk("rst_hazard", hazard_o, 0);
    chk("rst_stall", wb_stall_o, 0);
    chk("rst_regwrite", RegWrite_o, 0);
    @(negedge clk); rst_i = 1;
    @(posedge clk); #1;
    // single long-latency result, written the following cycle
    set_mu(1, 5, 32'hA5A5A5A5); tick();
    idle(); tick(); tick();
    // starvation: keep the buffer full while the pipeline writes every cycle
    set_wb(1, 1, 32'h11); set_mu(1, 10, 32'hA0); tick();
    set_mu(1, 11, 32'hB0); tick();
    set_mu(0, 0, 0);
    repeat (8) tick();
    idle(); repeat (3) tick();
    // WAW squash of the addr-7 entry
    set_wb(1, 1, 32'h22); set_mu(1, 7, 32'h70); tick();
    set_mu(1, 9, 32'h90); tick();
    set_mu(0, 0, 0); set_wb(1, 7, 32'h77); tick();
    idle(); repeat (3) tick();
    // address-0 handshakes and writebacks
    set_mu(1, 0, 32'hDEAD); set_wb(1, 0, 32'hBEEF); tick();
    idle(); tick();
    // hazard on a buffered addr-3 entry, cleared after its pop
    set_wb(1, 1, 32'h33); set_mu(1, 3, 32'h30); tick();
    set_mu(0, 0, 0); RSaddr_i = 3; tick();
    set_wb(0, 0, 0); tick(); tick();
    idle(); tick();
    // asynchronous reset with a full buffer
    set_wb(1, 1, 32'h44); set_mu(1, 12, 32'hC0); tick();
    set_mu(1, 13, 32'hD0); tick();
    #2 rst_i = 0; set_mu(0, 0, 0); set_wb(1, 4, 32'h4444);
    #1;
    chk("arst_mu_ready", mu_ready_o, 1);
    chk("arst_regwrite", RegWrite_o, 0);
    chk("arst_stall", wb_stall_o, 0);
    idle(); q.delete(); hold = 0; scnt = 0;
    #2 rst_i = 1;
    @(posedge clk); #1;
    repeat (3) tick();
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      set_wb($urandom_range(1, 0), 5'($urandom_range(7, 0)), $urandom);
      set_mu($urandom_range(1, 0), 5'($urandom_range(7, 0)), $urandom);
      if ($urandom_range(9, 0) < 6) wb_valid_i = 1;
      RSaddr_i = 5'($urandom_range(7, 0));
      RTaddr_i = 5'($urandom_range(7, 0));
      RDaddr_i = 5'($urandom_range(7, 0));
      tick();
    end
    idle(); repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end
endmodule

// File: doc/regwb_arbiter.md
REGWB_ARBITER -- requirements
Module: regwb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning consecutive cycles the buffer may be denied the write port while full before the pipeline is held.
REQ-002 SHALL have ports, clock and reset first:
- clk_i  in  1  single clock; all state updates on posedge.
- rst_i  in  1  reset, asynchronous, active-low.
- wb_valid_i  in  1  pipeline writeback request.
- wb_addr_i  in  5  pipeline destination register.
- wb_data_i  in  32  pipeline writeback data.
- mu_valid_i  in  1  long-latency unit result valid.
- mu_addr_i  in  5  long-latency destination register.
- mu_data_i  in  32  long-latency result data.
- mu_ready_o  out  1  buffer accepts mu result this cycle.
- RSaddr_i, RTaddr_i, RDaddr_i  in  5 each  decode-stage register addresses.
- hazard_o  out  1  decode address matches a buffered pending write.
- wb_stall_o  out  1  hold pipeline; its writeback is not taken.
- RegWrite_o  out  1  register-file write enable.
- RDaddr_o  out  5  register-file write address.
- RDdata_o  out  32  register-file write data.

Function
REQ-003 SHALL hold a 2-entry FIFO of {addr, data} for mu results, with 2-bit count, 1-bit head and tail pointers wrapping 1->0.
REQ-004 SHALL drive mu_ready_o = (count < 2), registered state only, no same-cycle pop credit.
REQ-005 SHALL enqueue at posedge when mu_valid_i && mu_ready_o && mu_addr_i != 0; a handshake with address 0 SHALL be accepted and discarded.
REQ-006 Port grant, combinational each cycle: if wb_valid_i && !wb_stall_o, then pipeline; else if count > 0, then FIFO head; else idle.
REQ-007 Pipeline grant SHALL drive RegWrite_o = (wb_addr_i != 0), RDaddr_o = wb_addr_i, RDdata_o = wb_data_i.
REQ-008 FIFO grant SHALL drive RegWrite_o = 1 with the head entry, and pop at posedge.
REQ-009 Idle SHALL drive RegWrite_o = 0, RDaddr_o = 0, RDdata_o = 0.
REQ-010 No bypass: a newly enqueued entry SHALL reach the write port no earlier than the next cycle (minimum latency 1).
REQ-011 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-012 Starvation FSM states:
- NORMAL: starve_cnt increments each cycle with count == 2 && pipeline grant; resets to 0 otherwise.
- NORMAL -> HOLD when starve_cnt reaches STARVE_MAX-1 in a starving cycle.
- HOLD: wb_stall_o = 1, so the FIFO wins the port.
- HOLD -> NORMAL after one FIFO pop, with starve_cnt = 0.
- wb_stall_o SHALL be 0 in NORMAL.
REQ-013 WAW squash: when the pipeline is granted with wb_addr_i != 0, every valid FIFO entry with the same address SHALL be invalidated and dropped from count at that posedge; a squashed head SHALL never be written.
REQ-014 hazard_o SHALL be 1 when any valid FIFO entry address is nonzero and equals RSaddr_i, RTaddr_i or RDaddr_i.
REQ-015 An incoming mu result in the same cycle SHALL be included in hazard_o.

Reset
REQ-016 rst_i low SHALL immediately clear:
- count, pointers, entry valids and starve_cnt to 0;
- the FSM to NORMAL;
- mu_ready_o to 1 and hazard_o, wb_stall_o, RegWrite_o to 0.
REQ-017 Reset asserted mid-operation SHALL discard buffered entries without any write.

Verification
REQ-018 Empty FIFO, mu (addr 5, 0xA5A5A5A5), no wb -> cycle+1: RegWrite_o=1, RDaddr_o=5, RDdata_o=0xA5A5A5A5; count 1 -> 0.
REQ-019 FIFO full, wb_valid_i every cycle, STARVE_MAX=4 -> after 4 wb grants, wb_stall_o=1 for one cycle, head written, then wb_stall_o=0.
REQ-020 FIFO holds addr 7 and 9, wb to addr 7 -> addr-7 entry dropped, only addr 9 later written.
REQ-021 mu handshake with addr 0 -> count unchanged, no write; wb to addr 0 -> RegWrite_o=0.
REQ-022 FIFO holds addr 3, RSaddr_i=3 -> hazard_o=1; after pop -> hazard_o=0.
REQ-023 Full FIFO, rst_i pulsed low between clock edges -> mu_ready_o=1, RegWrite_o=0 immediately, and no stale write after release.
